piso_tx: RTL
============

Name: piso_tx

Overview:
- Parallel-in serial-out frame transmitter. It is the sending end that feeds a serial shift chain or line with words.
- Accepts one WIDTH-bit word per valid/ready handshake and shifts it out one bit per clock.
- Outputs frame strobes (bit-valid, start-of-frame, end-of-frame) so a downstream serial receiver or shift chain can reassemble the word.
- Supports gapless back-to-back frames.

Parameters:
WIDTH, 8, word/frame length in bits; legal values are 2 or greater.
MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
din  input  WIDTH  parallel word to transmit.
din_valid  input  1  din holds a word offered for transmission.
din_ready  output  1  block can accept din on this edge.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a frame bit this cycle.
sof  output  1  first bit of a frame is on sout.
eof  output  1  last bit of a frame is on sout.
busy  output  1  frame in progress; same as sout_valid.

Behaviour:
- Reset:
  - rst=0 forces state=IDLE, shift register=0, bit counter=0 immediately, independent of clk.
  - While in reset: sout=0, sout_valid=0, sof=0, eof=0, busy=0, din_ready=1 (din_ready is decoded from state).
- State machine, two states:
  - IDLE: din_ready=1, sout_valid=0, sout=0. On an edge with din_valid=1: load din into the shift register, set cnt=WIDTH-1, go to SHIFT.
  - SHIFT: sout = shift-register bit [WIDTH-1] if MSB_FIRST=1, else bit [0]. sout_valid=1, busy=1, sof=(cnt==WIDTH-1), eof=(cnt==0).
    - Each edge with cnt>0: shift toward the output end (zero fill) and decrement cnt.
    - Edge with cnt==0 and din_valid=1: reload from din, cnt=WIDTH-1, stay in SHIFT. This is the gapless back-to-back case.
    - Edge with cnt==0 and din_valid=0: go to IDLE and clear the shift register.
- din_ready = (state==IDLE) or (state==SHIFT and cnt==0). It is combinational from registered state only and never depends on din_valid.
- Handshake:
  - A word is accepted only on an edge where din_valid=1 and din_ready=1.
  - din_valid while din_ready=0 is ignored; no state changes. Upstream holds din/din_valid until it sees ready.
  - din is sampled only on the accepting edge; later changes to din do not affect the frame in flight.
- Latency and throughput:
  - If accepted at edge N, the first bit is on sout during cycle N+1 and the last bit during cycle N+WIDTH.
  - One word per WIDTH cycles, with no idle gap between frames.
- Outputs are decoded only from registered state and contain no combinational path from inputs.
- Counter width is $clog2(WIDTH); it never wraps below 0.
- Reset mid-frame: the frame is aborted and outputs go to reset values asynchronously. There is no resumption after release; the next accepted word starts a fresh frame with sof.
- Simultaneous events: rst=0 overrides any handshake on the same edge.

Test Plan:
1. Hold rst=0 with din_valid=1, din=8'hFF, clk running -> sout=0, sout_valid=0, sof=0, eof=0, busy=0, din_ready=1; no frame starts until rst=1.
2. WIDTH=8, MSB_FIRST=1, single din=8'hA5 accepted at edge N ->
   - sout=1,0,1,0,0,1,0,1 on cycles N+1..N+8, sout_valid=1 throughout;
   - sof only at N+1, eof only at N+8;
   - din_ready=0 on N+1..N+7 and 1 at N+8;
   - idle (sout_valid=0, sout=0) at N+9.
3. Back-to-back: din_valid held, din=8'hA5 then 8'h3C on the second accept ->
   - 16 contiguous valid bits 10100101 00111100;
   - sof at N+1 and N+9, eof at N+8 and N+16, no gap.
4. MSB_FIRST=0, din=8'h01 -> sout=1 then seven 0s; with din=8'h80 -> seven 0s then 1.
5. Mid-frame, after accepting 8'hA5, drive din=8'h00 with din_valid=1 on cycles N+2..N+5 -> ignored; the 8'hA5 bit sequence is unchanged; 8'h00 is accepted at the eof edge N+8.
6. Pull rst=0 between clock edges after 3 bits of 8'hA5 -> all outputs 0 before the next edge. After release, din=8'hFF -> a full frame of eight 1s with sof on its first bit.

Source files
------------

// File: rtl/piso_tx_if.sv
// Handshake and serial-frame signals of the parallel-in serial-out transmitter.
// master: the upstream word source, which also watches the serial side.
// slave: the transmitter itself.
interface piso_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             sout;
   logic             sout_valid;
   logic             sof;
   logic             eof;
   logic             busy;

   modport master (
      output din, din_valid,
      input  din_ready, sout, sout_valid, sof, eof, busy
   );

   modport slave (
      input  din, din_valid,
      output din_ready, sout, sout_valid, sof, eof, busy
   );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out frame transmitter: takes one WIDTH-bit word per
// valid/ready handshake and shifts it out one bit per clock, with frame
// strobes. Back-to-back words are sent with no idle gap.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame on the line, ready for a word
// SHIFT | frame bit on sout; cnt = bits remaining after the current one
module piso_tx #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic     clk,
   input  logic     rst,
   piso_tx_if.slave bus
);
   localparam int               CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int               OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
   localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             accept;

   assign last_bit = (cnt == '0);
   // Ready is a function of registered state only, never of din_valid.
   assign bus.din_ready = (state == IDLE) || last_bit;
   assign accept        = bus.din_valid && bus.din_ready;

   // Load, shift and frame-sequencing state; reload on the last bit for gapless frames.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.din_valid) begin
                  sreg  <= bus.din;
                  cnt   <= CNT_MAX;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (!last_bit) begin
                  sreg <= (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0}
                                           : {1'b0, sreg[WIDTH-1:1]};
                  cnt  <= cnt - 1'b1;
               end else if (accept) begin
                  sreg <= bus.din;
                  cnt  <= CNT_MAX;
               end else begin
                  sreg  <= '0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               sreg  <= '0;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Frame outputs decoded straight from registers; no path from din/din_valid.
   always_comb begin
      bus.sout_valid = (state == SHIFT);
      bus.busy       = (state == SHIFT);
      bus.sout       = (state == SHIFT) && sreg[OUT_IDX];
      bus.sof        = (state == SHIFT) && (cnt == CNT_MAX);
      bus.eof        = (state == SHIFT) && last_bit;
   end
endmodule
